// File: rtl/sramx_cbus_arbiter_if.sv
// SRAM-x request channels and the downstream handshake bus as seen by sramx_cbus_arbiter.
// The master modport is the arbiter's view; slave is the surrounding core/bus environment.
interface sramx_cbus_arbiter_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [NUM_CH-1:0]            ch_req;
  logic [NUM_CH-1:0]            ch_wr;
  logic [3*NUM_CH-1:0]          ch_size;
  logic [ADDR_W*NUM_CH-1:0]     ch_addr;
  logic [(DATA_W/8)*NUM_CH-1:0] ch_wstrb;
  logic [DATA_W*NUM_CH-1:0]     ch_wdata;
  logic [NUM_CH-1:0]            ch_addr_ok;
  logic [NUM_CH-1:0]            ch_data_ok;
  logic [DATA_W-1:0]            ch_rdata;

  logic                         m_valid;
  logic                         m_wr;
  logic [2:0]                   m_size;
  logic [ADDR_W-1:0]            m_addr;
  logic [DATA_W/8-1:0]          m_wstrb;
  logic [DATA_W-1:0]            m_wdata;
  logic                         m_ready;
  logic                         m_resp_valid;
  logic                         m_resp_ready;
  logic [DATA_W-1:0]            m_rdata;

  modport master (
    input  ch_req, ch_wr, ch_size, ch_addr, ch_wstrb, ch_wdata,
    output ch_addr_ok, ch_data_ok, ch_rdata,
    output m_valid, m_wr, m_size, m_addr, m_wstrb, m_wdata, m_resp_ready,
    input  m_ready, m_resp_valid, m_rdata
  );

  modport slave (
    output ch_req, ch_wr, ch_size, ch_addr, ch_wstrb, ch_wdata,
    input  ch_addr_ok, ch_data_ok, ch_rdata,
    input  m_valid, m_wr, m_size, m_addr, m_wstrb, m_wdata, m_resp_ready,
    output m_ready, m_resp_valid, m_rdata
  );
endinterface

// File: rtl/sramx_cbus_arbiter.sv
// Round-robin N-channel SRAM-x arbiter with one outstanding downstream transaction.
// Optional watchdog abort (sticky bus_err) is enabled by defining CBUS_ARB_TIMEOUT_EN.
module sramx_cbus_arbiter #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  sramx_cbus_arbiter_if.master bus,
  output logic                 bus_err
);
  localparam int unsigned PtrW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned StrbW = DATA_W / 8;

  if (NUM_CH < 1 || DATA_W % 8 != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("sramx_cbus_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e            state_q, state_d;
  logic [PtrW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PtrW-1:0]   gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic [2:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [StrbW-1:0]  wstrb_q, wstrb_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_CH-1:0] addr_ok_q, addr_ok_d;
  logic [NUM_CH-1:0] data_ok_q, data_ok_d;

  logic              req_any;
  logic [PtrW-1:0]   sel_idx;
  logic              sel_wr;
  logic [2:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [StrbW-1:0]  sel_wstrb;
  logic [DATA_W-1:0] sel_wdata;
  logic [NUM_CH-1:0] sel_onehot, gnt_onehot;
  logic [PtrW-1:0]   ptr_inc;

  // First requesting channel at or above rr_ptr, wrapping at NUM_CH.
  always_comb begin
    logic [PtrW:0] pos;
    pos     = '0;
    req_any = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      pos = {1'b0, rr_ptr_q} + (PtrW+1)'(i);
      if (pos >= (PtrW+1)'(NUM_CH)) pos = pos - (PtrW+1)'(NUM_CH);
      if (!req_any && bus.ch_req[pos[PtrW-1:0]]) begin
        req_any = 1'b1;
        sel_idx = pos[PtrW-1:0];
      end
    end
  end

  always_comb begin
    sel_wr    = 1'b0;
    sel_size  = '0;
    sel_addr  = '0;
    sel_wstrb = '0;
    sel_wdata = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (sel_idx == PtrW'(i)) begin
        sel_wr    = bus.ch_wr[i];
        sel_size  = bus.ch_size[i*3 +: 3];
        sel_addr  = bus.ch_addr[i*ADDR_W +: ADDR_W];
        sel_wstrb = bus.ch_wstrb[i*StrbW +: StrbW];
        sel_wdata = bus.ch_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    sel_onehot          = '0;
    sel_onehot[sel_idx] = 1'b1;
    gnt_onehot          = '0;
    gnt_onehot[gnt_q]   = 1'b1;
  end

  assign ptr_inc = (gnt_q == PtrW'(NUM_CH - 1)) ? '0 : gnt_q + 1'b1;

`ifdef CBUS_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RepN = (DATA_W + 31) / 32;
  localparam logic [RepN*32-1:0] DeadRep = {RepN{32'hDEAD_BEEF}};

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            bus_err_q, bus_err_d;
  logic            timeout;

  assign timeout = (state_q != StIdle) && (cnt_q >= CntW'(TIMEOUT_CYCLES - 1));
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_d     = gnt_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    addr_ok_d = '0;
    data_ok_d = '0;
    unique case (state_q)
      StIdle: begin
        if (req_any) begin
          gnt_d     = sel_idx;
          wr_d      = sel_wr;
          size_d    = sel_size;
          addr_d    = sel_addr;
          wstrb_d   = sel_wr ? sel_wstrb : '0;
          wdata_d   = sel_wdata;
          addr_ok_d = sel_onehot;
          state_d   = StReq;
        end
      end
      StReq: begin
        if (bus.m_ready) state_d = StResp;
      end
      StResp: begin
        if (bus.m_resp_valid) begin
          rdata_d   = bus.m_rdata;
          rr_ptr_d  = ptr_inc;
          data_ok_d = gnt_onehot;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef CBUS_ARB_TIMEOUT_EN
    cnt_d     = (state_q == StIdle) ? '0 : cnt_q + 1'b1;
    bus_err_d = bus_err_q;
    // A handshake completing in the same cycle wins over the watchdog.
    if (timeout && !(state_q == StReq && bus.m_ready) &&
        !(state_q == StResp && bus.m_resp_valid)) begin
      state_d   = StIdle;
      rdata_d   = DeadRep[DATA_W-1:0];
      rr_ptr_d  = ptr_inc;
      data_ok_d = gnt_onehot;
      bus_err_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      rr_ptr_q  <= '0;
      gnt_q     <= '0;
      wr_q      <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      addr_ok_q <= '0;
      data_ok_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      gnt_q     <= gnt_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      addr_ok_q <= addr_ok_d;
      data_ok_q <= data_ok_d;
    end
  end

`ifdef CBUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end
`endif

  assign bus.ch_addr_ok   = addr_ok_q;
  assign bus.ch_data_ok   = data_ok_q;
  assign bus.ch_rdata     = rdata_q;
  assign bus.m_valid      = (state_q == StReq);
  assign bus.m_wr         = wr_q;
  assign bus.m_size       = size_q;
  assign bus.m_addr       = addr_q;
  assign bus.m_wstrb      = wstrb_q;
  assign bus.m_wdata      = wdata_q;
  assign bus.m_resp_ready = (state_q == StResp);
endmodule

// File: tb/tb_sramx_cbus_arbiter.sv
// Directed, table-driven bench for sramx_cbus_arbiter (NUM_CH=2) plus multi-cycle sequences.
// Defining CBUS_ARB_TIMEOUT_EN also exercises the watchdog with TIMEOUT_CYCLES=8.
module tb_sramx_cbus_arbiter;
  localparam int unsigned NumCh = 2;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
`ifdef CBUS_ARB_TIMEOUT_EN
  localparam int unsigned ToCycles = 8;
`else
  localparam int unsigned ToCycles = 255;
`endif

  logic clk = 1'b0;
  logic reset;
  logic bus_err;

  sramx_cbus_arbiter_if #(.NUM_CH(NumCh), .ADDR_W(AddrW), .DATA_W(DataW)) bus ();

  sramx_cbus_arbiter #(
    .NUM_CH        (NumCh),
    .ADDR_W        (AddrW),
    .DATA_W        (DataW),
    .TIMEOUT_CYCLES(ToCycles)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  req;
    logic        mready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  aok;
    logic [1:0]  dok;
    logic [31:0] e_rdata;
    logic        valid;
    logic        rready;
    int          ch;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mkv(logic [1:0] req, logic mready, logic rvalid, logic [31:0] rdata,
                               logic [1:0] aok, logic [1:0] dok, logic [31:0] e_rdata,
                               logic valid, logic rready, int ch);
    vec_t v;
    v.req = req; v.mready = mready; v.rvalid = rvalid; v.rdata = rdata;
    v.aok = aok; v.dok = dok; v.e_rdata = e_rdata; v.valid = valid; v.rready = rready;
    v.ch = ch;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ch0 carries a read (its wstrb must be masked), ch1 a write.
  task automatic check_outs(input string tag, input logic [1:0] aok, input logic [1:0] dok,
                            input logic [31:0] rd, input logic valid, input logic rready,
                            input int ch, input logic eerr);
    logic        e_wr;
    logic [2:0]  e_size;
    logic [31:0] e_addr;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata;
    if (ch == 1) begin
      e_wr = 1'b1; e_size = 3'd1; e_addr = 32'h8000_0010; e_wstrb = 4'h3; e_wdata = 32'h1234_5678;
    end else begin
      e_wr = 1'b0; e_size = 3'd2; e_addr = 32'h1FC0_0000; e_wstrb = 4'h0; e_wdata = 32'hAAAA_5555;
    end
    chk({tag, " addr_ok"}, 64'(bus.ch_addr_ok), 64'(aok));
    chk({tag, " data_ok"}, 64'(bus.ch_data_ok), 64'(dok));
    chk({tag, " rdata"}, 64'(bus.ch_rdata), 64'(rd));
    chk({tag, " m_valid"}, 64'(bus.m_valid), 64'(valid));
    chk({tag, " m_resp_ready"}, 64'(bus.m_resp_ready), 64'(rready));
    chk({tag, " m_wr"}, 64'(bus.m_wr), 64'(e_wr));
    chk({tag, " m_size"}, 64'(bus.m_size), 64'(e_size));
    chk({tag, " m_addr"}, 64'(bus.m_addr), 64'(e_addr));
    chk({tag, " m_wstrb"}, 64'(bus.m_wstrb), 64'(e_wstrb));
    chk({tag, " m_wdata"}, 64'(bus.m_wdata), 64'(e_wdata));
    chk({tag, " bus_err"}, 64'(bus_err), 64'(eerr));
  endtask

  // Minimum-latency transaction from IDLE with only channel ch requesting.
  task automatic run_txn(input string tag, input int ch, input logic [31:0] rd,
                         input logic [1:0] aok);
    bus.ch_req = aok; bus.m_ready = 1'b1; bus.m_resp_valid = 1'b0;
    tick();
    chk({tag, " addr_ok"}, 64'(bus.ch_addr_ok), 64'(aok));
    chk({tag, " m_valid"}, 64'(bus.m_valid), 64'(1));
    tick();
    bus.ch_req = 2'b00;
    chk({tag, " resp_ready"}, 64'(bus.m_resp_ready), 64'(1));
    bus.m_resp_valid = 1'b1; bus.m_rdata = rd;
    tick();
    chk({tag, " data_ok"}, 64'(bus.ch_data_ok), 64'(aok));
    chk({tag, " rdata"}, 64'(bus.ch_rdata), 64'(rd));
    bus.m_resp_valid = 1'b0; bus.m_ready = 1'b0;
    if (ch > 1) $display("run_txn: unexpected channel %0d", ch);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int found;
    int dok_seen;

    vecs[0]  = mkv(2'b01, 1, 0, 32'hBAD0_0000, 2'b01, 2'b00, 32'h0000_0000, 1, 0, 0);
    vecs[1]  = mkv(2'b01, 1, 0, 32'hBAD0_0001, 2'b00, 2'b00, 32'h0000_0000, 0, 1, 0);
    vecs[2]  = mkv(2'b00, 1, 1, 32'h3C08_BFAF, 2'b00, 2'b01, 32'h3C08_BFAF, 0, 0, 0);
    vecs[3]  = mkv(2'b00, 1, 0, 32'hBAD0_0003, 2'b00, 2'b00, 32'h3C08_BFAF, 0, 0, 0);
    vecs[4]  = mkv(2'b10, 0, 0, 32'hBAD0_0004, 2'b10, 2'b00, 32'h3C08_BFAF, 1, 0, 1);
    vecs[5]  = mkv(2'b10, 1, 0, 32'hBAD0_0005, 2'b00, 2'b00, 32'h3C08_BFAF, 0, 1, 1);
    vecs[6]  = mkv(2'b00, 0, 1, 32'hCAFE_F00D, 2'b00, 2'b10, 32'hCAFE_F00D, 0, 0, 1);
    vecs[7]  = mkv(2'b00, 0, 0, 32'hBAD0_0007, 2'b00, 2'b00, 32'hCAFE_F00D, 0, 0, 1);
    vecs[8]  = mkv(2'b11, 1, 1, 32'hBAD0_0008, 2'b01, 2'b00, 32'hCAFE_F00D, 1, 0, 0);
    vecs[9]  = mkv(2'b11, 1, 1, 32'hBAD0_0009, 2'b00, 2'b00, 32'hCAFE_F00D, 0, 1, 0);
    vecs[10] = mkv(2'b11, 1, 1, 32'h0000_0001, 2'b00, 2'b01, 32'h0000_0001, 0, 0, 0);
    vecs[11] = mkv(2'b11, 1, 1, 32'hBAD0_000B, 2'b10, 2'b00, 32'h0000_0001, 1, 0, 1);
    vecs[12] = mkv(2'b11, 1, 1, 32'hBAD0_000C, 2'b00, 2'b00, 32'h0000_0001, 0, 1, 1);
    vecs[13] = mkv(2'b11, 1, 1, 32'h0000_0002, 2'b00, 2'b10, 32'h0000_0002, 0, 0, 1);
    vecs[14] = mkv(2'b11, 1, 1, 32'hBAD0_000E, 2'b01, 2'b00, 32'h0000_0002, 1, 0, 0);
    vecs[15] = mkv(2'b11, 1, 1, 32'hBAD0_000F, 2'b00, 2'b00, 32'h0000_0002, 0, 1, 0);
    vecs[16] = mkv(2'b11, 1, 1, 32'h0000_0003, 2'b00, 2'b01, 32'h0000_0003, 0, 0, 0);
    vecs[17] = mkv(2'b11, 1, 1, 32'hBAD0_0011, 2'b10, 2'b00, 32'h0000_0003, 1, 0, 1);
    vecs[18] = mkv(2'b11, 1, 1, 32'hBAD0_0012, 2'b00, 2'b00, 32'h0000_0003, 0, 1, 1);
    vecs[19] = mkv(2'b11, 1, 1, 32'h0000_0004, 2'b00, 2'b10, 32'h0000_0004, 0, 0, 1);
    vecs[20] = mkv(2'b00, 0, 0, 32'hBAD0_0014, 2'b00, 2'b00, 32'h0000_0004, 0, 0, 1);

    bus.ch_wr    = 2'b10;
    bus.ch_size  = {3'd1, 3'd2};
    bus.ch_addr  = {32'h8000_0010, 32'h1FC0_0000};
    bus.ch_wstrb = {4'h3, 4'hF};
    bus.ch_wdata = {32'h1234_5678, 32'hAAAA_5555};
    bus.ch_req = 2'b00; bus.m_ready = 1'b0; bus.m_resp_valid = 1'b0; bus.m_rdata = '0;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    chk("rst addr_ok", 64'(bus.ch_addr_ok), 64'(0));
    chk("rst data_ok", 64'(bus.ch_data_ok), 64'(0));
    chk("rst rdata", 64'(bus.ch_rdata), 64'(0));
    chk("rst m_valid", 64'(bus.m_valid), 64'(0));
    chk("rst m_resp_ready", 64'(bus.m_resp_ready), 64'(0));
    chk("rst m_addr", 64'(bus.m_addr), 64'(0));
    chk("rst m_wr", 64'(bus.m_wr), 64'(0));
    chk("rst m_size", 64'(bus.m_size), 64'(0));
    chk("rst m_wstrb", 64'(bus.m_wstrb), 64'(0));
    chk("rst m_wdata", 64'(bus.m_wdata), 64'(0));
    chk("rst bus_err", 64'(bus_err), 64'(0));
    reset = 1'b0;

    // Single read, single write, then fairness with both channels requesting
    for (int i = 0; i < 21; i++) begin
      bus.ch_req       = vecs[i].req;
      bus.m_ready      = vecs[i].mready;
      bus.m_resp_valid = vecs[i].rvalid;
      bus.m_rdata      = vecs[i].rdata;
      tick();
      check_outs($sformatf("vec%0d", i), vecs[i].aok, vecs[i].dok, vecs[i].e_rdata,
                 vecs[i].valid, vecs[i].rready, vecs[i].ch, 1'b0);
    end

    // Backpressure: m_ready low for cycles 1..5; ch1 request meanwhile must be ignored
    bus.ch_req = 2'b01; bus.m_ready = 1'b0; bus.m_resp_valid = 1'b0;
    tick();
    check_outs("bp c1", 2'b01, 2'b00, 32'h0000_0004, 1, 0, 0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      bus.ch_req = 2'b10;
      tick();
      check_outs($sformatf("bp c%0d", k + 1), 2'b00, 2'b00, 32'h0000_0004, 1, 0, 0, 1'b0);
    end
    bus.m_ready = 1'b1;
    tick();
    check_outs("bp resp", 2'b00, 2'b00, 32'h0000_0004, 0, 1, 0, 1'b0);
    bus.m_resp_valid = 1'b1; bus.m_rdata = 32'h55AA_55AA;
    tick();
    check_outs("bp done", 2'b00, 2'b01, 32'h55AA_55AA, 0, 0, 0, 1'b0);
    bus.m_resp_valid = 1'b0;
    tick();
    check_outs("bp ch1 grant", 2'b10, 2'b00, 32'h55AA_55AA, 1, 0, 1, 1'b0);
    bus.ch_req = 2'b00;
    tick();
    bus.m_resp_valid = 1'b1; bus.m_rdata = 32'h6677_8899;
    tick();
    check_outs("bp ch1 done", 2'b00, 2'b10, 32'h6677_8899, 0, 0, 1, 1'b0);
    bus.m_resp_valid = 1'b0; bus.m_ready = 1'b0;

    // Reset while in RESP: rr_ptr is 1 beforehand, so a post-reset 0 grant proves it cleared
    run_txn("pre0", 0, 32'h0101_0101, 2'b01);
    bus.ch_req = 2'b10; bus.m_ready = 1'b1;
    tick();
    chk("rr1 addr_ok", 64'(bus.ch_addr_ok), 64'(2'b10));
    bus.ch_req = 2'b00;
    tick();
    chk("rr1 resp_ready", 64'(bus.m_resp_ready), 64'(1));
    reset = 1'b1; bus.m_resp_valid = 1'b1; bus.m_rdata = 32'hEEEE_EEEE;
    tick();
    chk("rstresp m_valid", 64'(bus.m_valid), 64'(0));
    chk("rstresp resp_ready", 64'(bus.m_resp_ready), 64'(0));
    chk("rstresp data_ok", 64'(bus.ch_data_ok), 64'(0));
    chk("rstresp rdata", 64'(bus.ch_rdata), 64'(0));
    reset = 1'b0; bus.m_resp_valid = 1'b0; bus.ch_req = 2'b11;
    tick();
    chk("post-rst grant", 64'(bus.ch_addr_ok), 64'(2'b01));
    chk("post-rst data_ok", 64'(bus.ch_data_ok), 64'(0));
    bus.ch_req = 2'b00;
    tick();
    bus.m_resp_valid = 1'b1; bus.m_rdata = 32'h2222_2222;
    tick();
    chk("post-rst done", 64'(bus.ch_data_ok), 64'(2'b01));
    chk("post-rst rdata", 64'(bus.ch_rdata), 64'(32'h2222_2222));
    bus.m_resp_valid = 1'b0; bus.m_ready = 1'b0;

    // Missing response: rr_ptr=1 but only ch0 requests
    bus.ch_req = 2'b01; bus.m_ready = 1'b1;
    tick();
    chk("nr grant", 64'(bus.ch_addr_ok), 64'(2'b01));
    bus.ch_req = 2'b00;
    tick();
    chk("nr resp_ready", 64'(bus.m_resp_ready), 64'(1));
`ifdef CBUS_ARB_TIMEOUT_EN
    found = 0;
    for (int k = 0; k < 50 && found == 0; k++) begin
      tick();
      if (bus.ch_data_ok != 2'b00) found = 1;
    end
    chk("to data_ok seen", 64'(found), 64'(1));
    chk("to data_ok", 64'(bus.ch_data_ok), 64'(2'b01));
    chk("to rdata", 64'(bus.ch_rdata), 64'(32'hDEAD_BEEF));
    chk("to bus_err", 64'(bus_err), 64'(1));
    chk("to m_valid", 64'(bus.m_valid), 64'(0));
    bus.ch_req = 2'b11;
    tick();
    chk("to rr advanced", 64'(bus.ch_addr_ok), 64'(2'b10));
    bus.ch_req = 2'b00;
    tick();
    bus.m_resp_valid = 1'b1; bus.m_rdata = 32'h3333_3333;
    tick();
    chk("to next done", 64'(bus.ch_data_ok), 64'(2'b10));
    chk("to bus_err sticky", 64'(bus_err), 64'(1));
    bus.m_resp_valid = 1'b0;
`else
    dok_seen = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (bus.ch_data_ok != 2'b00 || bus_err != 1'b0) dok_seen++;
    end
    chk("nr no data_ok", 64'(dok_seen), 64'(0));
    chk("nr bus_err", 64'(bus_err), 64'(0));
    chk("nr still waiting", 64'(bus.m_resp_ready), 64'(1));
    bus.m_resp_valid = 1'b1; bus.m_rdata = 32'h7777_7777;
    tick();
    chk("nr late done", 64'(bus.ch_data_ok), 64'(2'b01));
    chk("nr late rdata", 64'(bus.ch_rdata), 64'(32'h7777_7777));
    bus.m_resp_valid = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
